// File: rtl/adc_align_pkg.sv
// Shared definitions for the ADC alignment sequencer: state encoding,
// parameter defaults and width helpers.
package adc_align_pkg;

    localparam int unsigned N_CH_DEFAULT     = 8;
    localparam int unsigned SETTLE_DEFAULT   = 6;
    localparam int unsigned CONFIRM_DEFAULT  = 4;
    localparam int unsigned MAX_SLIP_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SLIP,
        S_WAIT,
        S_NEXT,
        S_DONE
    } align_state_e;

    // Bits needed to hold values 0..maxval inclusive.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/align_timer.sv
// Loadable down-counter; last_o flags the final cycle of a loaded interval.
module align_timer #(
    parameter int unsigned W = 3
)(
    input  logic         clk,
    input  logic         rstb,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Decrement saturates at zero so the counter can never wrap.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q <= W'(1));

endmodule

// File: rtl/adc_align_seq.sv
// Sequences bitslip-based frame alignment across N_CH ADC channels, one
// channel at a time, reporting sticky per-channel aligned/fail results.
module adc_align_seq
    import adc_align_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEFAULT,
    parameter int unsigned SETTLE   = SETTLE_DEFAULT,
    parameter int unsigned CONFIRM  = CONFIRM_DEFAULT,
    parameter int unsigned MAX_SLIP = MAX_SLIP_DEFAULT
)(
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      start,
    input  logic                      abort,
    input  logic [N_CH-1:0]           frame_ok,
    output logic [N_CH-1:0]           bitslip,
    output logic                      busy,
    output logic                      done,
    output logic [N_CH-1:0]           aligned,
    output logic [N_CH-1:0]           fail,
    output logic [ch_width(N_CH)-1:0] cur_ch
);

    localparam int unsigned CW   = ch_width(N_CH);
    localparam int unsigned SW   = cnt_width(MAX_SLIP);
    localparam int unsigned TMAX = (SETTLE > CONFIRM) ? SETTLE : CONFIRM;
    localparam int unsigned TW   = cnt_width(TMAX);

    align_state_e    state_q, state_d;
    logic [SW-1:0]   slip_q, slip_d;
    logic [CW-1:0]   cur_ch_q, cur_ch_d;
    logic [N_CH-1:0] aligned_q, aligned_d;
    logic [N_CH-1:0] fail_q, fail_d;

    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_dec;
    logic            tmr_last;

    // The timer holds the remaining confirm cycles in CHECK and the
    // remaining settle cycles in WAIT; reloading CONFIRM clears the confirm run.
    align_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rstb       (rstb),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .last_o     (tmr_last)
    );

    always_comb begin
        state_d   = state_q;
        slip_d    = slip_q;
        cur_ch_d  = cur_ch_q;
        aligned_d = aligned_q;
        fail_d    = fail_q;
        tmr_load  = 1'b0;
        tmr_val   = TW'(CONFIRM);
        tmr_dec   = 1'b0;
        bitslip   = '0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        aligned_d = '0;
                        fail_d    = '0;
                        cur_ch_d  = '0;
                        slip_d    = '0;
                        tmr_load  = 1'b1;
                        state_d   = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (frame_ok[cur_ch_q]) begin
                        if (tmr_last) begin
                            aligned_d[cur_ch_q] = 1'b1;
                            state_d             = S_NEXT;
                        end else begin
                            tmr_dec = 1'b1;
                        end
                    end else begin
                        tmr_load = 1'b1;
                        if (slip_q < SW'(MAX_SLIP)) begin
                            state_d = S_SLIP;
                        end else begin
                            fail_d[cur_ch_q] = 1'b1;
                            state_d          = S_NEXT;
                        end
                    end
                end
                S_SLIP: begin
                    bitslip[cur_ch_q] = 1'b1;
                    slip_d            = slip_q + SW'(1);
                    tmr_load          = 1'b1;
                    tmr_val           = TW'(SETTLE);
                    state_d           = S_WAIT;
                end
                S_WAIT: begin
                    if (tmr_last) begin
                        tmr_load = 1'b1;
                        state_d  = S_CHECK;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                S_NEXT: begin
                    slip_d   = '0;
                    tmr_load = 1'b1;
                    if (cur_ch_q == CW'(N_CH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        cur_ch_d = cur_ch_q + CW'(1);
                        state_d  = S_CHECK;
                    end
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= S_IDLE;
            slip_q    <= '0;
            cur_ch_q  <= '0;
            aligned_q <= '0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            slip_q    <= slip_d;
            cur_ch_q  <= cur_ch_d;
            aligned_q <= aligned_d;
            fail_q    <= fail_d;
        end
    end

    assign aligned = aligned_q;
    assign fail    = fail_q;
    assign cur_ch  = cur_ch_q;

endmodule

// File: tb/tb_adc_align_seq.sv
// Scoreboard bench for adc_align_seq: a per-channel frame model responds to
// bitslip pulses, and each completed pass is checked against a reference model.
module tb_adc_align_seq;
    import adc_align_pkg::*;

    localparam int N_CH     = 8;
    localparam int SETTLE   = 6;
    localparam int CONFIRM  = 4;
    localparam int MAX_SLIP = 8;
    localparam int CW       = 3;

    logic            clk   = 1'b0;
    logic            rstb  = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [N_CH-1:0] frame_ok = '0;
    logic [N_CH-1:0] bitslip;
    logic            busy;
    logic            done;
    logic [N_CH-1:0] aligned;
    logic [N_CH-1:0] fail;
    logic [CW-1:0]   cur_ch;

    always #5 clk = ~clk;

    adc_align_seq #(
        .N_CH     (N_CH),
        .SETTLE   (SETTLE),
        .CONFIRM  (CONFIRM),
        .MAX_SLIP (MAX_SLIP)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .start    (start),
        .abort    (abort),
        .frame_ok (frame_ok),
        .bitslip  (bitslip),
        .busy     (busy),
        .done     (done),
        .aligned  (aligned),
        .fail     (fail),
        .cur_ch   (cur_ch)
    );

    typedef struct packed {
        logic [N_CH-1:0][7:0] slips;
        logic [N_CH-1:0]      aln;
        logic [N_CH-1:0]      fl;
        logic                 chkLat;
        logic [31:0]          lat;
    } exp_t;

    exp_t expQ[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    // need[c]: slips channel c requires before frame_ok rises; -1 = 1,1,1,0 toggler.
    int   need[N_CH];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Expected pass outcome from the channel needs, by counting cycles per channel.
    function automatic exp_t refModel();
        exp_t e;
        e        = '0;
        e.chkLat = 1'b1;
        e.lat    = 32'd1;
        for (int c = 0; c < N_CH; c++) begin
            if (need[c] < 0) begin
                e.fl[c]    = 1'b1;
                e.slips[c] = 8'(MAX_SLIP);
                e.chkLat   = 1'b0;
            end else if (need[c] <= MAX_SLIP) begin
                e.aln[c]   = 1'b1;
                e.slips[c] = 8'(need[c]);
                e.lat      = e.lat + 32'(need[c] * (SETTLE + 2) + CONFIRM + 1);
            end else begin
                e.fl[c]    = 1'b1;
                e.slips[c] = 8'(MAX_SLIP);
                e.lat      = e.lat + 32'(MAX_SLIP * (SETTLE + 2) + 2);
            end
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Channel model: frame_ok follows slips received this pass, updated mid-cycle.
    int   slipsSeen[N_CH];
    int   phase = 0;
    logic mBusyPrev = 1'b0;
    always @(negedge clk) begin
        phase++;
        if (busy && !mBusyPrev) begin
            for (int c = 0; c < N_CH; c++) slipsSeen[c] = 0;
        end
        mBusyPrev = busy;
        for (int c = 0; c < N_CH; c++) begin
            if (bitslip[c]) slipsSeen[c]++;
            frame_ok[c] = (need[c] < 0) ? ((phase % 4) != 3) : (slipsSeen[c] >= need[c]);
        end
    end

    // Monitor: tracks pulses per pass and scores each done against the queue.
    int   slipCnt[N_CH];
    int   lastSlip[N_CH];
    int   passStart = 0;
    logic monBusyPrev = 1'b0;
    logic donePrev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy && !monBusyPrev) begin
            passStart = cyc;
            for (int c = 0; c < N_CH; c++) slipCnt[c] = 0;
        end
        monBusyPrev = busy;
        if (bitslip != '0) begin
            checkOutput("bitslip onehot", 32'($onehot(bitslip)), 32'd1);
            for (int c = 0; c < N_CH; c++) begin
                if (bitslip[c]) begin
                    if (slipCnt[c] > 0)
                        checkOutput($sformatf("slip spacing ch%0d", c),
                                    32'((cyc - lastSlip[c]) >= (SETTLE + 2)), 32'd1);
                    slipCnt[c]++;
                    lastSlip[c] = cyc;
                end
            end
        end
        if (done) begin
            checkOutput("done one-cycle", 32'(donePrev), 32'd0);
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected done: got done=1, expected no pass to complete");
            end else begin
                e = expQ.pop_front();
                checkOutput("aligned", 32'(aligned), 32'(e.aln));
                checkOutput("fail", 32'(fail), 32'(e.fl));
                checkOutput("aligned/fail overlap", 32'(aligned & fail), 32'd0);
                for (int c = 0; c < N_CH; c++)
                    checkOutput($sformatf("slip count ch%0d", c), 32'(slipCnt[c]), 32'(e.slips[c]));
                if (e.chkLat)
                    checkOutput("done latency", 32'(cyc - passStart + 1), e.lat);
            end
        end
        donePrev = done;
    end

    task automatic applyStimulus(input bit expectDone);
        @(posedge clk);
        #1;
        if (expectDone) expQ.push_back(refModel());
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " idle timeout"}, 32'(n < 3000), 32'd1);
        repeat (3) @(posedge clk);
    endtask

    task automatic setNeed(input int v);
        for (int c = 0; c < N_CH; c++) need[c] = v;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " bitslip"}, 32'(bitslip), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " aligned"}, 32'(aligned), 32'd0);
        checkOutput({tag, " fail"}, 32'(fail), 32'd0);
        checkOutput({tag, " cur_ch"}, 32'(cur_ch), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        setNeed(0);
        #12;
        checkAllZero("reset");
        #10 rstb = 1'b1;
        repeat (2) @(posedge clk);

        setNeed(0);
        applyStimulus(1);
        waitIdle("all aligned");

        setNeed(0);
        need[3] = 3;
        applyStimulus(1);
        waitIdle("ch3 three slips");

        setNeed(0);
        need[5] = 99;
        applyStimulus(1);
        waitIdle("ch5 stuck");

        setNeed(0);
        need[2] = -1;
        applyStimulus(1);
        waitIdle("ch2 toggle");

        // Abort during WAIT on channel 4.
        setNeed(0);
        need[4] = 2;
        applyStimulus(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bitslip[4] && n < 500);
        checkOutput("abort reached ch4 slip", 32'(n < 500), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort cycle bitslip", 32'(bitslip), 32'd0);
        checkOutput("abort cycle done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("after abort busy", 32'(busy), 32'd0);
        checkOutput("after abort aligned", 32'(aligned), 32'h0F);
        checkOutput("after abort fail", 32'(fail), 32'd0);
        checkOutput("after abort cur_ch", 32'(cur_ch), 32'd4);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abort+start busy", 32'(busy), 32'd0);
        checkOutput("abort+start aligned kept", 32'(aligned), 32'h0F);
        setNeed(0);
        applyStimulus(1);
        checkOutput("restart clears aligned", 32'(aligned), 32'd0);
        checkOutput("restart busy", 32'(busy), 32'd1);
        waitIdle("after abort restart");

        // Reset asserted mid-pass.
        for (int c = 0; c < N_CH; c++) need[c] = int'($urandom_range(0, 3));
        applyStimulus(0);
        repeat (20) @(posedge clk);
        #3 rstb = 1'b0;
        #1;
        checkAllZero("mid-pass reset");
        repeat (2) @(posedge clk);
        #3 rstb = 1'b1;
        repeat (3) @(posedge clk);
        setNeed(0);
        applyStimulus(1);
        waitIdle("after reset restart");

        // Randomised passes with stray start pulses while busy.
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 15) < 2) need[c] = -1;
                else need[c] = int'($urandom_range(0, 10));
            end
            applyStimulus(1);
            repeat ($urandom_range(5, 35)) @(posedge clk);
            #1;
            if (busy) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            waitIdle($sformatf("random pass %0d", p));
        end

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
